stopwatch_ctrl: RTL and testbench

Stopwatch sequencer driven by the 100 Hz square-wave output of the team's clock generator. Detects rising edges of that wave synchronously in the clk domain and keeps a BCD mm:ss.cc count. A 4-state FSM (IDLE/RUN/LAP/PAUSE) is driven by single-cycle button pulses. Output digits feed the seven-segment scan logic, which is clocked by the generator's clk_ssd.

---
 rtl/stopwatch_ctrl.sv | 133 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: counts 100 Hz tick edges as BCD mm:ss.cc with IDLE/RUN/LAP/PAUSE control.
// Define OVERFLOW_HOLD_EN to saturate at MAX_MIN:59.99 and force PAUSE instead of wrapping.
module stopwatch_ctrl #(
  parameter int MAX_MIN = 59,
  parameter int STATE_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_100,
  input  logic               btn_ss,
  input  logic               btn_lr,
  output logic [23:0]        disp_bcd,
  output logic [STATE_W-1:0] state,
  output logic               running,
  output logic               overflow
);

  localparam logic [STATE_W-1:0] IDLE  = STATE_W'(0);
  localparam logic [STATE_W-1:0] RUN   = STATE_W'(1);
  localparam logic [STATE_W-1:0] LAP   = STATE_W'(2);
  localparam logic [STATE_W-1:0] PAUSE = STATE_W'(3);

  localparam logic [3:0]  MIN_T   = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MIN_O   = 4'(MAX_MIN % 10);
  localparam logic [23:0] CNT_MAX = {MIN_T, MIN_O, 16'h5999};

  logic               tick_d;
  logic [23:0]        cnt, snap;
  logic [23:0]        cnt_nxt, snap_nxt, disp_nxt;
  logic [STATE_W-1:0] state_nxt;
  logic               ovf_nxt, tick_edge, counting, hold_stop;

  // Ripple the carry through the digits; minute wrap is handled by the caller.
  function automatic logic [23:0] bcd_inc(input logic [23:0] c);
    logic [23:0] r;
    r = c;
    if (c[3:0] != 4'd9) r[3:0] = c[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (c[7:4] != 4'd9) r[7:4] = c[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (c[11:8] != 4'd9) r[11:8] = c[11:8] + 4'd1;
        else begin
          r[11:8] = 4'd0;
          if (c[15:12] != 4'd5) r[15:12] = c[15:12] + 4'd1;
          else begin
            r[15:12] = 4'd0;
            if (c[19:16] != 4'd9) r[19:16] = c[19:16] + 4'd1;
            else begin
              r[19:16] = 4'd0;
              r[23:20] = c[23:20] + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    tick_edge = tick_100 & ~tick_d;
    counting  = (state == RUN) || (state == LAP);
    state_nxt = state;
    cnt_nxt   = cnt;
    snap_nxt  = snap;
    ovf_nxt   = overflow;
    hold_stop = 1'b0;

    // Increment decision uses the pre-transition state.
    if (tick_edge && counting) begin
      if (cnt == CNT_MAX) begin
`ifdef OVERFLOW_HOLD_EN
        hold_stop = 1'b1;
`else
        cnt_nxt = '0;
`endif
        ovf_nxt = 1'b1;
      end else begin
        cnt_nxt = bcd_inc(cnt);
      end
    end

    // btn_ss is checked first everywhere so it wins over btn_lr.
    case (state)
      IDLE:  if (btn_ss) state_nxt = RUN;
      RUN: begin
        if (btn_ss) state_nxt = PAUSE;
        else if (btn_lr) begin
          state_nxt = LAP;
          snap_nxt  = cnt;
        end
      end
      LAP: begin
        if (btn_ss) state_nxt = PAUSE;
        else if (btn_lr) state_nxt = RUN;
      end
      PAUSE: begin
        if (btn_ss) state_nxt = RUN;
        else if (btn_lr) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (hold_stop) state_nxt = PAUSE;
    disp_nxt = (state_nxt == LAP) ? snap_nxt : cnt_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_d   <= 1'b0;
      cnt      <= '0;
      snap     <= '0;
      state    <= IDLE;
      running  <= 1'b0;
      overflow <= 1'b0;
      disp_bcd <= '0;
    end else begin
      tick_d   <= tick_100;
      cnt      <= cnt_nxt;
      snap     <= snap_nxt;
      state    <= state_nxt;
      running  <= (state_nxt == RUN) || (state_nxt == LAP);
      overflow <= ovf_nxt;
      disp_bcd <= disp_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: centisecond-integer reference model, per-clock expected queue.
module tb_stopwatch_ctrl;
  localparam int MAX_MIN = 59;
  localparam int MAX_CS  = (MAX_MIN + 1) * 6000 - 1;

  logic        clk = 0, rst_n = 0, tick_100 = 0, btn_ss = 0, btn_lr = 0;
  logic [23:0] disp_bcd;
  logic [1:0]  state;
  logic        running, overflow;

  stopwatch_ctrl #(.MAX_MIN(MAX_MIN), .STATE_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .tick_100(tick_100), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .disp_bcd(disp_bcd), .state(state), .running(running), .overflow(overflow));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] disp;
    logic [1:0]  st;
    logic        run;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0;

  // Reference model state: count and snapshot in plain centiseconds.
  int m_cnt = 0, m_snap = 0, m_st = 0;
  bit m_ovf = 0, m_tick_d = 0;

  function automatic logic [23:0] to_bcd(input int cs);
    int mn, sc, c;
    mn = cs / 6000;
    sc = (cs / 100) % 60;
    c  = cs % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic cmp(input string name, input logic [23:0] got, input logic [23:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every clock edge the DUT presents a new output word.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("sb_disp", disp_bcd, e.disp);
      cmp("sb_state", 24'(state), 24'(e.st));
      cmp("sb_running", 24'(running), 24'(e.run));
      cmp("sb_overflow", 24'(overflow), 24'(e.ovf));
    end
  end

  task automatic step(input bit ss, input bit lr, input bit tk);
    exp_t e;
    bit ed, stop;
    int ns, ncnt, nsnap;
    bit novf;
    @(negedge clk);
    btn_ss = ss; btn_lr = lr; tick_100 = tk;
    ed = tk && !m_tick_d;
    m_tick_d = tk;
    ns = m_st; ncnt = m_cnt; nsnap = m_snap; novf = m_ovf; stop = 0;
    if (ed && (m_st == 1 || m_st == 2)) begin
      if (m_cnt == MAX_CS) begin
        novf = 1;
`ifdef OVERFLOW_HOLD_EN
        stop = 1;
`else
        ncnt = 0;
`endif
      end else ncnt = m_cnt + 1;
    end
    case (m_st)
      0: if (ss) ns = 1;
      1: if (ss) ns = 3; else if (lr) begin ns = 2; nsnap = m_cnt; end
      2: if (ss) ns = 3; else if (lr) ns = 1;
      default: if (ss) ns = 1; else if (lr) begin ns = 0; ncnt = 0; novf = 0; end
    endcase
    if (stop) ns = 3;
    m_st = ns; m_cnt = ncnt; m_snap = nsnap; m_ovf = novf;
    e.disp = to_bcd(ns == 2 ? nsnap : ncnt);
    e.st   = 2'(ns);
    e.run  = (ns == 1 || ns == 2);
    e.ovf  = novf;
    q.push_back(e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 1);
      step(0, 0, 0);
    end
  endtask

  // Fixed-value check right after the edge that applies the last step.
  task automatic chk_now(input string name, input logic [23:0] d, input logic [1:0] s);
    @(posedge clk);
    #2;
    cmp({name, "_disp"}, disp_bcd, d);
    cmp({name, "_state"}, 24'(state), 24'(s));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_disp", disp_bcd, 24'h0);
    cmp("reset_flags", {21'h0, state, running}, 24'h0);
    @(negedge clk);
    rst_n = 1;

    step(1, 0, 0);
    ticks(150);
    chk_now("run150", 24'h000150, 2'd1);
    cmp("run150_running", 24'(running), 24'h1);

    step(0, 1, 0);
    ticks(30);
    chk_now("lap_frozen", 24'h000150, 2'd2);
    step(0, 1, 0);
    chk_now("lap_release", 24'h000180, 2'd1);

    ticks(5999 - 180);
    chk_now("pre_min", 24'h005999, 2'd1);
    ticks(1);
    chk_now("min_carry", 24'h010000, 2'd1);
    step(1, 0, 0);
    ticks(10);
    chk_now("pause_hold", 24'h010000, 2'd3);
    step(0, 1, 0);
    chk_now("clear", 24'h000000, 2'd0);

    step(1, 0, 0);
    ticks(5);
    step(1, 1, 1);
    chk_now("both_btn", 24'h000006, 2'd3);
    step(0, 0, 0);

    // Preload the counter to the last legal value while paused.
    @(negedge clk);
    force dut.cnt = 24'h595999;
    #1;
    release dut.cnt;
    m_cnt = MAX_CS;
    step(1, 0, 0);
    step(0, 0, 1);
`ifdef OVERFLOW_HOLD_EN
    chk_now("ovf", 24'h595999, 2'd3);
`else
    chk_now("ovf", 24'h000000, 2'd1);
`endif
    cmp("ovf_flag", 24'(overflow), 24'h1);
    step(0, 0, 0);
    ticks(3);
    if (m_st == 1) step(1, 0, 0);
    step(0, 1, 0);
    chk_now("ovf_clear", 24'h000000, 2'd0);
    cmp("ovf_cleared", 24'(overflow), 24'h0);

    step(1, 0, 0);
    ticks(1234);
    chk_now("pre_rst", 24'h001234, 2'd1);
    @(negedge clk);
    rst_n = 0;
    tick_100 = 1;
    #1;
    cmp("async_rst_disp", disp_bcd, 24'h0);
    cmp("async_rst_flags", {20'h0, state, running, overflow}, 24'h0);
    m_cnt = 0; m_snap = 0; m_st = 0; m_ovf = 0; m_tick_d = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    m_tick_d = 1;
    chk_now("rst_release", 24'h000000, 2'd0);
    step(1, 0, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    chk_now("post_rst_tick", 24'h000001, 2'd1);

    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));

    repeat (2) @(posedge clk);
    #2;
    cmp("queue_drained", 24'(q.size()), 24'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
